priority_resolver: RTL and testbench

- Clocked priority resolver directly upstream of the PIC control logic.
- Takes masked request state (IRR, IMR) and in-service state (ISR), picks the winning IR line under fully-nested, optionally rotating priority, and drives int_request and interrupt_index to the control logic.
- Freezes its decision between INTA pulses and resolves EOI commands into one-hot ISR clear pulses.

---
 rtl/priority_resolver_if.sv | 41 ++++
 rtl/priority_resolver.sv | 126 ++++++++++++
 tb/tb_priority_resolver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/priority_resolver_if.sv
// Bundle of request/in-service state, EOI/priority commands and resolver outputs
// exchanged between the PIC control logic (master) and the priority resolver (slave).
interface priority_resolver_if #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
);
  logic [NUM_IRQ-1:0] irr;
  logic [NUM_IRQ-1:0] imr;
  logic [NUM_IRQ-1:0] isr;
  logic               read_priority;
  logic               freezing;
  logic               eoi;
  logic               eoi_specific;
  logic [IDX_W-1:0]   eoi_level;
  logic               rotate_en;
  logic               set_priority;
  logic [IDX_W-1:0]   priority_level;
  logic               int_request;
  logic [IDX_W-1:0]   interrupt_index;
  logic               spurious;
  logic               read_priority_ack;
  logic [NUM_IRQ-1:0] isr_clear;
  logic [IDX_W-1:0]   lowest_ptr;
  logic [1:0]         dbg_state;

  // Handshake: int_request is a level held until read_priority rises (the lock);
  // read_priority_ack toggles on that same edge and the lock ends on a freezing fall.
  modport master (
    output irr, imr, isr, read_priority, freezing, eoi, eoi_specific, eoi_level,
           rotate_en, set_priority, priority_level,
    input  int_request, interrupt_index, spurious, read_priority_ack, isr_clear,
           lowest_ptr, dbg_state
  );

  modport slave (
    input  irr, imr, isr, read_priority, freezing, eoi, eoi_specific, eoi_level,
           rotate_en, set_priority, priority_level,
    output int_request, interrupt_index, spurious, read_priority_ack, isr_clear,
           lowest_ptr, dbg_state
  );
endinterface

// File: rtl/priority_resolver.sv
// 8259A-style priority resolver: fully nested, rotatable priority with a
// request/lock/freeze FSM and EOI-to-ISR-clear decoding.
module priority_resolver (
  input  logic                 clk,
  input  logic                 rst_n,
  priority_resolver_if.slave   bus
);
  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, LOCKED = 2'd2} state_t;

  state_t             state_q;
  logic               int_request_q;
  logic [IDX_W-1:0]   index_q;
  logic               spurious_q;
  logic               ack_q;
  logic [NUM_IRQ-1:0] isr_clear_q;
  logic [IDX_W-1:0]   lowest_q;
  logic               rp_q;
  logic               frz_q;

  logic [NUM_IRQ-1:0] cand;
  logic [IDX_W-1:0]   scan_idx;
  logic               win_found, isr_found, qualified;
  logic [IDX_W-1:0]   win_idx, win_rank, isr_idx, isr_rank, eoi_target;
  logic               rp_rise, frz_fall;

  assign cand     = bus.irr & ~bus.imr;
  assign rp_rise  = bus.read_priority & ~rp_q;
  assign frz_fall = ~bus.freezing & frz_q;

  // Scan from the highest-priority slot (lowest_ptr+1) downwards; rank 0 is highest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_rank  = '0;
    isr_found = 1'b0;
    isr_idx   = '0;
    isr_rank  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      scan_idx = lowest_q + IDX_W'(1) + IDX_W'(k);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
        win_rank  = IDX_W'(k);
      end
      if (!isr_found && bus.isr[scan_idx]) begin
        isr_found = 1'b1;
        isr_idx   = scan_idx;
        isr_rank  = IDX_W'(k);
      end
    end
  end

  assign qualified  = win_found && (!isr_found || (win_rank < isr_rank));
  assign eoi_target = bus.eoi_specific ? bus.eoi_level : isr_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      int_request_q <= 1'b0;
      index_q       <= '0;
      spurious_q    <= 1'b0;
      ack_q         <= 1'b0;
      isr_clear_q   <= '0;
      lowest_q      <= IDX_W'(NUM_IRQ - 1);
      rp_q          <= 1'b0;
      frz_q         <= 1'b0;
    end else begin
      rp_q        <= bus.read_priority;
      frz_q       <= bus.freezing;
      isr_clear_q <= '0;
      if (bus.eoi && (bus.eoi_specific || isr_found)) begin
        isr_clear_q <= {{(NUM_IRQ-1){1'b0}}, 1'b1} << eoi_target;
        if (bus.rotate_en) lowest_q <= eoi_target;
      end
      // Placed after the EOI rotation so an explicit priority set takes precedence.
      if (bus.set_priority) lowest_q <= bus.priority_level;

      case (state_q)
        IDLE: begin
          if (rp_rise) begin
            state_q       <= LOCKED;
            ack_q         <= ~ack_q;
            int_request_q <= qualified;
            spurious_q    <= ~qualified;
            index_q       <= qualified ? win_idx : IDX_W'(NUM_IRQ - 1);
          end else if (qualified) begin
            state_q       <= REQUEST;
            int_request_q <= 1'b1;
            index_q       <= win_idx;
          end
        end
        REQUEST: begin
          if (rp_rise) begin
            state_q <= LOCKED;
            ack_q   <= ~ack_q;
          end else if (!qualified) begin
            state_q       <= IDLE;
            int_request_q <= 1'b0;
          end else begin
            index_q <= win_idx;
          end
        end
        LOCKED: begin
          if (frz_fall) begin
            state_q       <= IDLE;
            int_request_q <= 1'b0;
            spurious_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.int_request       = int_request_q;
  assign bus.interrupt_index   = index_q;
  assign bus.spurious          = spurious_q;
  assign bus.read_priority_ack = ack_q;
  assign bus.isr_clear         = isr_clear_q;
  assign bus.lowest_ptr        = lowest_q;
  assign bus.dbg_state         = state_q;
endmodule

// File: tb/tb_priority_resolver.sv
// Directed bench for priority_resolver: request, masking, nesting, lock/freeze,
// spurious lock, EOI rotation, priority-set collision and reset during lock.
module tb_priority_resolver;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  priority_resolver_if bus ();

  priority_resolver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [7:0] ST_IDLE    = 8'd0;
  localparam logic [7:0] ST_REQUEST = 8'd1;
  localparam logic [7:0] ST_LOCKED  = 8'd2;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.irr            = '0;
    bus.imr            = '0;
    bus.isr            = '0;
    bus.read_priority  = 1'b0;
    bus.freezing       = 1'b0;
    bus.eoi            = 1'b0;
    bus.eoi_specific   = 1'b0;
    bus.eoi_level      = '0;
    bus.rotate_en      = 1'b0;
    bus.set_priority   = 1'b0;
    bus.priority_level = '0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_int_request"}, {7'd0, bus.int_request}, 8'd0);
    chk({tag, "_index"}, {5'd0, bus.interrupt_index}, 8'd0);
    chk({tag, "_spurious"}, {7'd0, bus.spurious}, 8'd0);
    chk({tag, "_ack"}, {7'd0, bus.read_priority_ack}, 8'd0);
    chk({tag, "_isr_clear"}, bus.isr_clear, 8'h00);
    chk({tag, "_lowest_ptr"}, {5'd0, bus.lowest_ptr}, 8'd7);
    chk({tag, "_state"}, {6'd0, bus.dbg_state}, ST_IDLE);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk_reset_values("reset");

    // Basic request: IR2 beats IR5 with default priority
    rst_n   = 1'b1;
    bus.irr = 8'h24;
    step();
    chk("basic_req", {7'd0, bus.int_request}, 8'd1);
    chk("basic_idx", {5'd0, bus.interrupt_index}, 8'd2);

    // Mask IR2 -> IR5 wins
    bus.imr = 8'h04;
    step();
    chk("mask_idx", {5'd0, bus.interrupt_index}, 8'd5);
    chk("mask_req", {7'd0, bus.int_request}, 8'd1);

    // IR3 in service outranks IR5 -> request withdrawn
    bus.isr = 8'h08;
    step();
    chk("nest_drop", {7'd0, bus.int_request}, 8'd0);
    chk("nest_state", {6'd0, bus.dbg_state}, ST_IDLE);

    bus.isr = 8'h00;
    bus.imr = 8'h00;
    step();
    chk("rereq_idx", {5'd0, bus.interrupt_index}, 8'd2);

    // Lock on read_priority rise
    bus.read_priority = 1'b1;
    bus.freezing      = 1'b1;
    step();
    chk("lock_ack", {7'd0, bus.read_priority_ack}, 8'd1);
    chk("lock_state", {6'd0, bus.dbg_state}, ST_LOCKED);
    chk("lock_idx", {5'd0, bus.interrupt_index}, 8'd2);

    bus.irr = 8'h01;
    step();
    chk("hold_idx", {5'd0, bus.interrupt_index}, 8'd2);
    chk("hold_req", {7'd0, bus.int_request}, 8'd1);

    bus.read_priority = 1'b0;
    bus.freezing      = 1'b0;
    step();
    chk("unfreeze_req", {7'd0, bus.int_request}, 8'd0);
    step();
    chk("after_freeze_req", {7'd0, bus.int_request}, 8'd1);
    chk("after_freeze_idx", {5'd0, bus.interrupt_index}, 8'd0);

    // Spurious lock with no candidate
    bus.irr = 8'h00;
    step();
    chk("spur_pre_req", {7'd0, bus.int_request}, 8'd0);
    bus.read_priority = 1'b1;
    bus.freezing      = 1'b1;
    step();
    chk("spur_idx", {5'd0, bus.interrupt_index}, 8'd7);
    chk("spur_flag", {7'd0, bus.spurious}, 8'd1);
    chk("spur_req", {7'd0, bus.int_request}, 8'd0);
    chk("spur_ack", {7'd0, bus.read_priority_ack}, 8'd0);
    bus.read_priority = 1'b0;
    bus.freezing      = 1'b0;
    step();
    chk("spur_clear", {7'd0, bus.spurious}, 8'd0);
    chk("spur_state", {6'd0, bus.dbg_state}, ST_IDLE);

    // Rotating non-specific EOI on IR4
    bus.isr       = 8'h10;
    bus.eoi       = 1'b1;
    bus.rotate_en = 1'b1;
    step();
    chk("rot_clear", bus.isr_clear, 8'h10);
    chk("rot_lowest", {5'd0, bus.lowest_ptr}, 8'd4);
    bus.eoi       = 1'b0;
    bus.rotate_en = 1'b0;
    bus.isr       = 8'h00;
    bus.irr       = 8'h21;
    step();
    chk("rot_pulse_end", bus.isr_clear, 8'h00);
    chk("rot_idx", {5'd0, bus.interrupt_index}, 8'd5);
    chk("rot_req", {7'd0, bus.int_request}, 8'd1);

    // Non-specific EOI with empty ISR does nothing
    bus.irr       = 8'h00;
    bus.eoi       = 1'b1;
    bus.rotate_en = 1'b1;
    step();
    chk("empty_eoi_clear", bus.isr_clear, 8'h00);
    chk("empty_eoi_lowest", {5'd0, bus.lowest_ptr}, 8'd4);

    // set_priority collides with rotating specific EOI
    bus.eoi_specific   = 1'b1;
    bus.eoi_level      = 3'd6;
    bus.set_priority   = 1'b1;
    bus.priority_level = 3'd1;
    step();
    chk("collide_lowest", {5'd0, bus.lowest_ptr}, 8'd1);
    chk("collide_clear", bus.isr_clear, 8'h40);
    idle_inputs();

    // Reset while locked
    bus.irr = 8'h04;
    step();
    chk("pre_lock_req", {7'd0, bus.int_request}, 8'd1);
    bus.read_priority = 1'b1;
    bus.freezing      = 1'b1;
    step();
    chk("pre_reset_state", {6'd0, bus.dbg_state}, ST_LOCKED);
    chk("pre_reset_ack", {7'd0, bus.read_priority_ack}, 8'd1);
    rst_n = 1'b0;
    idle_inputs();
    step();
    chk_reset_values("lock_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
